// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the uart_msg_tx message sequencer.
// Defining UART_MSG_CRLF_EN appends a CR/LF terminator to every message.
package uart_msg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    ACK  = 3'd2,
    DONE = 3'd3,
    GAP  = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_MSG_CRLF_EN
  localparam int unsigned CRLF_LEN = 2;
`else
  localparam int unsigned CRLF_LEN = 0;
`endif

  function automatic int unsigned tot_len(input int unsigned msg_len);
    return msg_len + CRLF_LEN;
  endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// Combinational byte selector: returns message byte idx, or CR/LF past the
// end of the message when UART_MSG_CRLF_EN is defined.
module uart_msg_rom
  import uart_msg_pkg::*;
#(
  parameter int unsigned          MSG_LEN = 12,
  parameter logic [8*MSG_LEN-1:0] MSG     = "Hello World!",
  parameter int unsigned          IDX_W   = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data
);

  int unsigned idx_u;

  always_comb begin
    idx_u = 32'(idx);
    data  = '0;
    // First character sits in the top byte of the string literal.
    for (int unsigned k = 0; k < MSG_LEN; k++) begin
      if (idx_u == k) data = MSG[8*(MSG_LEN-1-k) +: 8];
    end
`ifdef UART_MSG_CRLF_EN
    if (idx_u == MSG_LEN)     data = ASCII_CR;
    if (idx_u == MSG_LEN + 1) data = ASCII_LF;
`endif
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Streams a fixed ASCII message byte by byte into a uart transmitter, one-shot
// or free-running with an idle gap. UART_MSG_CRLF_EN adds a CR/LF terminator.
module uart_msg_tx
  import uart_msg_pkg::*;
#(
  parameter int unsigned          MSG_LEN    = 12,
  parameter logic [8*MSG_LEN-1:0] MSG        = "Hello World!",
  parameter int unsigned          REPEAT     = 1,
  parameter int unsigned          GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TOT_LEN = tot_len(MSG_LEN);
  localparam int unsigned IDX_W   = $clog2(TOT_LEN + 1);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit REPEAT_EN = (REPEAT != 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] rom_idx;
  logic [7:0]       rom_data;

  // The ROM looks up the byte about to be sent, so tx_data loads on SEND entry.
  assign rom_idx = (state_q == DONE) ? idx_q + 1'b1 : '0;

  uart_msg_rom #(
    .MSG_LEN(MSG_LEN),
    .MSG    (MSG),
    .IDX_W  (IDX_W)
  ) u_rom (
    .idx (rom_idx),
    .data(rom_data)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    tx_start_d = (state_q == SEND);
    busy_d     = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        gap_d = '0;
        if (REPEAT_EN ? enable : start) begin
          state_d   = SEND;
          tx_data_d = rom_data;
        end
      end
      SEND: state_d = ACK;
      ACK: begin
        if (tx_busy) state_d = DONE;
      end
      DONE: begin
        if (!tx_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 1'b1;
            state_d   = SEND;
            tx_data_d = rom_data;
          end else begin
            idx_d  = '0;
            done_d = 1'b1;
            gap_d  = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: a one-shot "Hi!" instance and a repeating
// "Hello World!" instance with a 5-cycle gap, each driven by a uart stand-in.
module tb_uart_msg_tx;

`ifdef UART_MSG_CRLF_EN
  localparam int CRLF = 2;
`else
  localparam int CRLF = 0;
`endif
  localparam int TOT1 = 3 + CRLF;
  localparam int TOT2 = 12 + CRLF;
  // uart stand-in busy for 10 cycles: start-to-start 13, last start to done 12.
  localparam int BYTE_PERIOD   = 13;
  localparam int LAST_TO_DONE  = 12;
  localparam int DONE_TO_START = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, en1 = 1'b0, start2 = 1'b0, en2 = 1'b0;
  logic       txb1, txb2;
  logic       tx_start1, tx_start2, busy1, busy2, done1, done2;
  logic [7:0] tx_data1, tx_data2;
  int         cnt1 = 0, cnt2 = 0, cyc = 0;
  int         n_cmp = 0, n_err = 0;

  logic [7:0] exp1 [0:4]  = '{8'h48, 8'h69, 8'h21, 8'h0D, 8'h0A};
  logic [7:0] exp2 [0:13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                              8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

  logic [7:0] bytes1[$], bytes2[$];
  int         starts1[$], starts2[$], dones1[$], dones2[$];

  uart_msg_tx #(.MSG_LEN(3), .MSG("Hi!"), .REPEAT(0), .GAP_CYCLES(0)) u_one (
    .clk(clk), .rst(rst), .enable(en1), .start(start1), .tx_busy(txb1),
    .tx_start(tx_start1), .tx_data(tx_data1), .busy(busy1), .done(done1)
  );

  uart_msg_tx #(.MSG_LEN(12), .MSG("Hello World!"), .REPEAT(1), .GAP_CYCLES(5)) u_rep (
    .clk(clk), .rst(rst), .enable(en2), .start(start2), .tx_busy(txb2),
    .tx_start(tx_start2), .tx_data(tx_data2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start1)     cnt1 <= 10;
    else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    if (tx_start2)     cnt2 <= 10;
    else if (cnt2 != 0) cnt2 <= cnt2 - 1;
  end
  assign txb1 = (cnt1 != 0);
  assign txb2 = (cnt2 != 0);

  always @(negedge clk) begin
    if (tx_start1 === 1'b1) begin bytes1.push_back(tx_data1); starts1.push_back(cyc); end
    if (done1 === 1'b1) dones1.push_back(cyc);
    if (tx_start2 === 1'b1) begin bytes2.push_back(tx_data2); starts2.push_back(cyc); end
    if (done2 === 1'b1) dones2.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    bytes1.delete(); starts1.delete(); dones1.delete();
    bytes2.delete(); starts2.delete(); dones2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++; if (tx_start1 !== 1'b0) begin n_err++; $display("FAIL reset_tx_start1 got %b exp 0", tx_start1); end
    n_cmp++; if (tx_data1 !== 8'h00) begin n_err++; $display("FAIL reset_tx_data1 got %h exp 00", tx_data1); end
    n_cmp++; if (busy1 !== 1'b0)     begin n_err++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    n_cmp++; if (done1 !== 1'b0)     begin n_err++; $display("FAIL reset_done1 got %b exp 0", done1); end
    n_cmp++; if (tx_start2 !== 1'b0) begin n_err++; $display("FAIL reset_tx_start2 got %b exp 0", tx_start2); end
    n_cmp++; if (tx_data2 !== 8'h00) begin n_err++; $display("FAIL reset_tx_data2 got %h exp 00", tx_data2); end
    n_cmp++; if (busy2 !== 1'b0)     begin n_err++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
    n_cmp++; if (done2 !== 1'b0)     begin n_err++; $display("FAIL reset_done2 got %b exp 0", done2); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_one_shot();
    int k;
    clear_logs();
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(1);
    n_cmp++; if (tx_start1 !== 1'b1) begin n_err++; $display("FAIL latency_tx_start got %b exp 1", tx_start1); end
    n_cmp++; if (busy1 !== 1'b1)     begin n_err++; $display("FAIL latency_busy got %b exp 1", busy1); end
    n_cmp++; if (tx_data1 !== 8'h48) begin n_err++; $display("FAIL latency_tx_data got %h exp 48", tx_data1); end
    k = 0;
    while (busy1 !== 1'b0 && k < 300) begin tick(1); k++; end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL one_shot_idle got busy=%b exp 0", busy1); end
    n_cmp++;
    if (bytes1.size() !== TOT1) begin
      n_err++; $display("FAIL one_shot_count got %0d exp %0d", bytes1.size(), TOT1);
    end else begin
      for (int i = 0; i < TOT1; i++) begin
        n_cmp++;
        if (bytes1[i] !== exp1[i]) begin n_err++; $display("FAIL one_shot_byte%0d got %h exp %h", i, bytes1[i], exp1[i]); end
      end
      n_cmp++;
      if (starts1[1] - starts1[0] !== BYTE_PERIOD) begin
        n_err++; $display("FAIL inter_byte got %0d exp %0d", starts1[1] - starts1[0], BYTE_PERIOD);
      end
    end
    n_cmp++;
    if (dones1.size() !== 1) begin
      n_err++; $display("FAIL one_shot_done_count got %0d exp 1", dones1.size());
    end else if (bytes1.size() == TOT1) begin
      n_cmp++;
      if (dones1[0] - starts1[TOT1-1] !== LAST_TO_DONE) begin
        n_err++; $display("FAIL done_timing got %0d exp %0d", dones1[0] - starts1[TOT1-1], LAST_TO_DONE);
      end
    end
  endtask

  task automatic test_repeat_gap();
    int k;
    clear_logs();
    en2 = 1'b1;
    k = 0;
    while (dones2.size() < 2 && k < 1000) begin tick(1); k++; end
    en2 = 1'b0;
    n_cmp++; if (dones2.size() < 2) begin n_err++; $display("FAIL repeat_done_count got %0d exp 2", dones2.size()); end
    k = 0;
    while (busy2 !== 1'b0 && k < 400) begin tick(1); k++; end
    n_cmp++;
    if (starts2.size() !== 2 * TOT2 || dones2.size() !== 2) begin
      n_err++; $display("FAIL repeat_count got %0d starts %0d dones exp %0d starts 2 dones",
                        starts2.size(), dones2.size(), 2 * TOT2);
    end else begin
      n_cmp++;
      if (starts2[TOT2] - dones2[0] !== DONE_TO_START) begin
        n_err++; $display("FAIL gap_spacing got %0d exp %0d", starts2[TOT2] - dones2[0], DONE_TO_START);
      end
      n_cmp++;
      if (dones2[1] - dones2[0] !== BYTE_PERIOD * TOT2 + 6) begin
        n_err++; $display("FAIL repeat_period got %0d exp %0d", dones2[1] - dones2[0], BYTE_PERIOD * TOT2 + 6);
      end
      for (int i = 0; i < 2 * TOT2; i++) begin
        n_cmp++;
        if (bytes2[i] !== exp2[i % TOT2]) begin
          n_err++; $display("FAIL repeat_byte%0d got %h exp %h", i, bytes2[i], exp2[i % TOT2]);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int k;
    clear_logs();
    en2 = 1'b1;
    k = 0;
    while (starts2.size() < 2 && k < 100) begin tick(1); k++; end
    en2 = 1'b0;
    k = 0;
    while (busy2 !== 1'b0 && k < 400) begin tick(1); k++; end
    tick(30);
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL drop_idle got busy=%b exp 0", busy2); end
    n_cmp++; if (starts2.size() !== TOT2) begin n_err++; $display("FAIL drop_count got %0d exp %0d", starts2.size(), TOT2); end
    n_cmp++; if (dones2.size() !== 1) begin n_err++; $display("FAIL drop_done_count got %0d exp 1", dones2.size()); end
    if (bytes2.size() == TOT2) begin
      n_cmp++;
      if (bytes2[TOT2-1] !== exp2[TOT2-1]) begin
        n_err++; $display("FAIL drop_last_byte got %h exp %h", bytes2[TOT2-1], exp2[TOT2-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_logs();
    en2 = 1'b1;
    k = 0;
    while (starts2.size() < 5 && k < 200) begin tick(1); k++; end
    n_cmp++; if (tx_data2 !== 8'h6F) begin n_err++; $display("FAIL mid_byte5 got %h exp 6f", tx_data2); end
    rst = 1'b1;
    en2 = 1'b0;
    tick(1);
    n_cmp++; if (tx_start2 !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_start got %b exp 0", tx_start2); end
    n_cmp++; if (tx_data2 !== 8'h00) begin n_err++; $display("FAIL mid_rst_tx_data got %h exp 00", tx_data2); end
    n_cmp++; if (busy2 !== 1'b0)     begin n_err++; $display("FAIL mid_rst_busy got %b exp 0", busy2); end
    n_cmp++; if (done2 !== 1'b0)     begin n_err++; $display("FAIL mid_rst_done got %b exp 0", done2); end
    rst = 1'b0;
    tick(20);
    clear_logs();
    en2 = 1'b1;
    k = 0;
    while (starts2.size() < 1 && k < 50) begin tick(1); k++; end
    en2 = 1'b0;
    n_cmp++;
    if (bytes2.size() < 1) begin
      n_err++; $display("FAIL mid_restart got no tx_start exp one");
    end else if (bytes2[0] !== 8'h48) begin
      n_err++; $display("FAIL mid_restart_byte got %h exp 48", bytes2[0]);
    end
    k = 0;
    while (busy2 !== 1'b0 && k < 400) begin tick(1); k++; end
  endtask

  task automatic test_start_while_busy();
    int k;
    clear_logs();
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(20);
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL swb_busy got %b exp 1", busy1); end
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    k = 0;
    while (busy1 !== 1'b0 && k < 300) begin tick(1); k++; end
    tick(40);
    n_cmp++; if (starts1.size() !== TOT1) begin n_err++; $display("FAIL swb_count got %0d exp %0d", starts1.size(), TOT1); end
    n_cmp++; if (dones1.size() !== 1) begin n_err++; $display("FAIL swb_done_count got %0d exp 1", dones1.size()); end
    n_cmp++;
    if (bytes1.size() < 1) begin
      n_err++; $display("FAIL swb_first got no tx_start exp one");
    end else if (bytes1[0] !== 8'h48) begin
      n_err++; $display("FAIL swb_first_byte got %h exp 48", bytes1[0]);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_repeat_gap();
    test_enable_drop();
    test_reset_mid();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
